sd_dat_tx_seq: RTL

SD_DAT_TX_SEQ -- requirements
Module: sd_dat_tx_seq

---
 rtl/sd_dat_pkg.sv | 33 +++
 rtl/sd_crc_16.sv | 40 ++++
 rtl/sd_dat_tx_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_dat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_dat_pkg : shared types/constants for the SD DAT0 block transmitter |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package sd_dat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_END   = 3'd4,
    ST_DONE  = 3'd5
  } sd_tx_state_e;

  localparam logic START_BIT   = 1'b0;
  localparam logic END_BIT     = 1'b1;
  localparam int   CRC_LEN     = 16;
  localparam int   MAX_BLK_LEN = 512;

  localparam logic [CRC_LEN-1:0] CRC16_POLY = 16'h1021;

  // One serial step of the SD CRC-16 (x^16 + x^12 + x^5 + 1, MSB first).
  function automatic logic [CRC_LEN-1:0] crc16_step(input logic [CRC_LEN-1:0] crc,
                                                    input logic bitval);
    logic fb;
    fb = bitval ^ crc[CRC_LEN-1];
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_crc_16 : bit-serial CRC-16 engine with synchronous clear (RST)     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module sd_crc_16
  import sd_dat_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RST,
  input  logic               BITVAL,
  input  logic               Enable,
  output logic [CRC_LEN-1:0] CRC
);

  logic [CRC_LEN-1:0] crc_q;
  logic [CRC_LEN-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (RST) begin
      crc_d = '0;
    end else if (Enable) begin
      crc_d = crc16_step(crc_q, BITVAL);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_dat_tx_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_dat_tx_seq : SD DAT0 single-block transmitter (start/data/CRC/end) |
// | Option: SD_DAT_TX_CRC_INJ_EN adds crc_inj to corrupt CRC[0].          |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module sd_dat_tx_seq
  import sd_dat_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             abort,
`ifdef SD_DAT_TX_CRC_INJ_EN
  input  logic             crc_inj,
`endif
  output logic             dat_out,
  output logic             dat_oe,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int             CNT_W    = $clog2(CRC_LEN);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_LEN - 1);

  sd_tx_state_e state_q, state_d;

  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   crc_cnt_q, crc_cnt_d;
  logic [LEN_W-1:0]   tx_left_q, tx_left_d;
  logic [LEN_W-1:0]   acc_left_q, acc_left_d;

  logic               w_start_ok;
  logic               w_take;
  logic               w_byte_edge;
  logic               w_load;
  logic               w_underrun;
  logic               w_crc_inv;
  logic               w_crc_bit;
  logic [CRC_LEN-1:0] w_crc;

  assign w_start_ok  = (state_q == ST_IDLE) && start && (blk_len != '0);
  assign w_take      = data_valid && data_ready;
  // A byte boundary is where the shift register needs its next byte.
  assign w_byte_edge = (state_q == ST_START) ||
                       ((state_q == ST_DATA) && (bit_cnt_q == 3'd7) && (tx_left_q != '0));
  assign w_load      = w_byte_edge && hold_full_q;
  assign w_underrun  = w_byte_edge && !hold_full_q;

`ifdef SD_DAT_TX_CRC_INJ_EN
  logic crc_inj_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      crc_inj_q <= 1'b0;
    end else if (w_start_ok) begin
      crc_inj_q <= crc_inj;
    end
  end

  assign w_crc_inv = crc_inj_q;
`else
  assign w_crc_inv = 1'b0;
`endif

  assign w_crc_bit = w_crc[CRC_LAST - crc_cnt_q] ^ (w_crc_inv && (crc_cnt_q == CRC_LAST));

  sd_crc_16 u_crc (
    .CLK    (CLK),
    .RST_N  (RST),
    .RST    (w_start_ok),
    .BITVAL (dat_out),
    .Enable (state_q == ST_DATA),
    .CRC    (w_crc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (w_start_ok) state_d = ST_START;
        ST_START: state_d = w_underrun ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            if (tx_left_q == '0) begin
              state_d = ST_CRC;
            end else if (w_underrun) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_CRC:   if (crc_cnt_q == CRC_LAST) state_d = ST_END;
        ST_END:   state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dat_oe     = 1'b1;
    dat_out    = END_BIT;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    data_ready = !hold_full_q && (acc_left_q != '0);
    unique case (state_q)
      ST_IDLE: begin
        dat_oe     = 1'b0;
        busy       = 1'b0;
        err        = start && (blk_len == '0);
        // The first byte must be captured together with start.
        data_ready = w_start_ok;
      end
      ST_START: begin
        dat_out = START_BIT;
        err     = w_underrun && !abort;
      end
      ST_DATA: begin
        dat_out = shift_q[7];
        err     = w_underrun && !abort;
      end
      ST_CRC:  dat_out = w_crc_bit;
      ST_END:  dat_out = END_BIT;
      ST_DONE: begin
        dat_oe = 1'b0;
        done   = !abort;
      end
      default: begin
        dat_oe     = 1'b0;
        busy       = 1'b0;
        data_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = '0;
    crc_cnt_d   = '0;
    tx_left_d   = tx_left_q;
    acc_left_d  = acc_left_q;

    if (w_take) begin
      hold_d = data_in;
    end

    if (state_q == ST_IDLE) begin
      hold_full_d = w_take;
      if (w_start_ok) begin
        tx_left_d  = blk_len;
        acc_left_d = blk_len - LEN_W'(w_take);
      end
    end else begin
      hold_full_d = (hold_full_q && !w_load) || w_take;
      if (w_take) begin
        acc_left_d = acc_left_q - LEN_W'(1);
      end
    end

    if (w_load) begin
      shift_d   = hold_q;
      tx_left_d = tx_left_q - LEN_W'(1);
    end else if (state_q == ST_DATA) begin
      shift_d = {shift_q[6:0], 1'b0};
    end

    if (state_q == ST_DATA) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (state_q == ST_CRC) begin
      crc_cnt_d = crc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      crc_cnt_q   <= '0;
      tx_left_q   <= '0;
      acc_left_q  <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
      tx_left_q   <= tx_left_d;
      acc_left_q  <= acc_left_d;
    end
  end

endmodule
`default_nettype wire
